// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 constants, sequencer FSM states and the RFC 8439 initial-state builder.
package chacha20_pkg;

  localparam int WORD_W      = 32;
  localparam int STATE_WORDS = 16;
  localparam int STATE_W     = WORD_W * STATE_WORDS;

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h6170_7865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320_646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b20_6574;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_OUT,
    ST_FIN
  } seq_state_e;

  // Word i lands at [32i+31:32i]: sigma, key, counter, nonce.
  function automatic logic [STATE_W-1:0] build_state(
    input logic [255:0]        key,
    input logic [95:0]         nonce,
    input logic [WORD_W-1:0]   ctr
  );
    return {nonce, ctr, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

endpackage

// File: rtl/chacha20_block_sequencer_if.sv
// Keystream valid/ready bus between the block sequencer and its consumer.
interface chacha20_block_sequencer_if;
  import chacha20_pkg::*;

  logic               ks_valid;
  logic               ks_ready;
  logic [STATE_W-1:0] ks_data;
  logic               ks_last;

  modport master (output ks_valid, output ks_data, output ks_last, input ks_ready);
  modport slave  (input ks_valid, input ks_data, input ks_last, output ks_ready);

endinterface

// File: rtl/chacha20_feed_forward.sv
// Feed-forward stage: per-word mod 2^32 sum of the initial state and the 20-round output.
module chacha20_feed_forward
  import chacha20_pkg::*;
(
  input  logic [STATE_W-1:0] init_state_i,
  input  logic [STATE_W-1:0] round_out_i,
  output logic [STATE_W-1:0] sum_o
);

  for (genvar i = 0; i < STATE_WORDS; i++) begin : g_word
    assign sum_o[WORD_W*i +: WORD_W] = init_state_i[WORD_W*i +: WORD_W]
                                     + round_out_i[WORD_W*i +: WORD_W];
  end

endmodule

// File: rtl/chacha20_block_sequencer.sv
// Sequences ChaCha20 keystream blocks around a fixed-latency serial encoder.
// Optional macro CHACHA20_CTR_OVERFLOW_EN: stop the job and flag ctr_overflow on counter wrap.
module chacha20_block_sequencer
  import chacha20_pkg::*;
#(
  parameter int ENCODER_LATENCY = 80
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [255:0]        key,
  input  logic [95:0]         nonce,
  input  logic [WORD_W-1:0]   counter_init,
  input  logic [15:0]         num_blocks,
  output logic                busy,
  output logic                enc_set_state,
  output logic [STATE_W-1:0]  enc_round_input,
  input  logic [STATE_W-1:0]  enc_round_output,
  chacha20_block_sequencer_if.master ks,
`ifdef CHACHA20_CTR_OVERFLOW_EN
  output logic                ctr_overflow,
`endif
  output logic                done
);

  localparam int LAT_W = $clog2(ENCODER_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ENCODER_LATENCY - 1);

  seq_state_e         state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [WORD_W-1:0]  ctr_q, ctr_d;
  logic [15:0]        remain_q, remain_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [STATE_W-1:0] enc_in_q, enc_in_d;
  logic [STATE_W-1:0] ks_data_q, ks_data_d;
`ifdef CHACHA20_CTR_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [STATE_W-1:0] init_state;
  logic [STATE_W-1:0] ff_sum;

  // The counter only advances on a handshake, so this is the state of the block in flight.
  assign init_state = build_state(key_q, nonce_q, ctr_q);

  chacha20_feed_forward u_feed_forward (
    .init_state_i (init_state),
    .round_out_i  (enc_round_output),
    .sum_o        (ff_sum)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case can infer a latch.
    state_d   = state_q;
    key_d     = key_q;
    nonce_d   = nonce_q;
    ctr_d     = ctr_q;
    remain_d  = remain_q;
    lat_d     = lat_q;
    enc_in_d  = enc_in_q;
    ks_data_d = ks_data_q;
`ifdef CHACHA20_CTR_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d    = key;
          nonce_d  = nonce;
          ctr_d    = counter_init;
          remain_d = num_blocks;
`ifdef CHACHA20_CTR_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
          state_d  = (num_blocks == 16'd0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        enc_in_d = init_state;
        lat_d    = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (lat_q == LAT_LAST) begin
          ks_data_d = ff_sum;
          state_d   = ST_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_OUT: begin
        if (ks.ks_ready) begin
          remain_d = remain_q - 16'd1;
          ctr_d    = ctr_q + 32'd1;
          if (remain_q == 16'd1) begin
            state_d = ST_FIN;
          end
`ifdef CHACHA20_CTR_OVERFLOW_EN
          else if (ctr_q == '1) begin
            state_d = ST_FIN;
            ovf_d   = 1'b1;
          end
`endif
          else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      remain_q  <= '0;
      lat_q     <= '0;
      enc_in_q  <= '0;
      ks_data_q <= '0;
`ifdef CHACHA20_CTR_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      ctr_q     <= ctr_d;
      remain_q  <= remain_d;
      lat_q     <= lat_d;
      enc_in_q  <= enc_in_d;
      ks_data_q <= ks_data_d;
`ifdef CHACHA20_CTR_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign enc_set_state   = (state_q == ST_LOAD);
  assign enc_round_input = enc_set_state ? init_state : enc_in_q;
  assign ks.ks_valid     = (state_q == ST_OUT);
  assign ks.ks_data      = ks_data_q;
  assign ks.ks_last      = (state_q == ST_OUT) && (remain_q == 16'd1);
  assign done            = (state_q == ST_FIN);
`ifdef CHACHA20_CTR_OVERFLOW_EN
  assign ctr_overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_chacha20_block_sequencer.sv
// Directed bench for chacha20_block_sequencer with a behavioural fixed-latency ChaCha20 encoder.
module tb_chacha20_block_sequencer;

  localparam int LAT = 12;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter_init;
  logic [15:0]  num_blocks;
  logic         busy;
  logic         enc_set_state;
  logic [511:0] enc_round_input;
  logic [511:0] enc_round_output;
  logic         done;
  logic         ctr_overflow;

  int vectors = 0;
  int miscompares = 0;

  chacha20_block_sequencer_if ks_bus ();

  chacha20_block_sequencer #(.ENCODER_LATENCY(LAT)) dut (
    .clock            (clock),
    .clear            (clear),
    .start            (start),
    .key              (key),
    .nonce            (nonce),
    .counter_init     (counter_init),
    .num_blocks       (num_blocks),
    .busy             (busy),
    .enc_set_state    (enc_set_state),
    .enc_round_input  (enc_round_input),
    .enc_round_output (enc_round_output),
    .ks               (ks_bus),
`ifdef CHACHA20_CTR_OVERFLOW_EN
    .ctr_overflow     (ctr_overflow),
`endif
    .done             (done)
  );

`ifndef CHACHA20_CTR_OVERFLOW_EN
  assign ctr_overflow = 1'b0;
`endif

  always #5 clock = ~clock;

  // RFC 8439 section 2.3.2 serialized keystream block, as little-endian words.
  localparam logic [511:0] RFC_KS = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
  localparam logic [255:0] RFC_KEY = {
    32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
    32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0] RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] qr(input logic [511:0] v, input int a, input int b,
                                      input int c, input int d);
    logic [31:0] wa, wb, wc, wd;
    wa = v[32*a +: 32]; wb = v[32*b +: 32]; wc = v[32*c +: 32]; wd = v[32*d +: 32];
    wa = wa + wb; wd = rotl(wd ^ wa, 16);
    wc = wc + wd; wb = rotl(wb ^ wc, 12);
    wa = wa + wb; wd = rotl(wd ^ wa, 8);
    wc = wc + wd; wb = rotl(wb ^ wc, 7);
    v[32*a +: 32] = wa; v[32*b +: 32] = wb; v[32*c +: 32] = wc; v[32*d +: 32] = wd;
    return v;
  endfunction

  function automatic logic [511:0] chacha_rounds(input logic [511:0] s);
    logic [511:0] v;
    v = s;
    for (int r = 0; r < 10; r++) begin
      v = qr(v, 0, 4, 8, 12); v = qr(v, 1, 5, 9, 13);
      v = qr(v, 2, 6, 10, 14); v = qr(v, 3, 7, 11, 15);
      v = qr(v, 0, 5, 10, 15); v = qr(v, 1, 6, 11, 12);
      v = qr(v, 2, 7, 8, 13);  v = qr(v, 3, 4, 9, 14);
    end
    return v;
  endfunction

  function automatic logic [511:0] tb_state(input logic [255:0] k, input logic [95:0] n,
                                            input logic [31:0] c);
    return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  endfunction

  function automatic logic [511:0] exp_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [511:0] s, r, o;
    s = tb_state(k, n, c);
    r = chacha_rounds(s);
    for (int i = 0; i < 16; i++) o[32*i +: 32] = s[32*i +: 32] + r[32*i +: 32];
    return o;
  endfunction

  // Behavioural encoder: garbage until LAT cycles after the set_state cycle.
  logic [511:0] enc_st = '0;
  int           enc_cnt = 0;
  always @(posedge clock) begin
    if (enc_set_state) begin
      enc_st  <= enc_round_input;
      enc_cnt <= 1;
    end else if (enc_cnt != 0 && enc_cnt < 1000) begin
      enc_cnt <= enc_cnt + 1;
    end
  end
  assign enc_round_output = (enc_cnt >= LAT) ? chacha_rounds(enc_st) : {16{32'hdeadbeef}};

  logic [31:0] ss_words[$];
  int done_cnt = 0;
  int valid_rises = 0;
  logic valid_prev = 1'b0;
  always @(posedge clock) begin
    if (enc_set_state) ss_words.push_back(enc_round_input[415:384]);
    if (done) done_cnt <= done_cnt + 1;
    if (ks_bus.ks_valid && !valid_prev) valid_rises <= valid_rises + 1;
    valid_prev <= ks_bus.ks_valid;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_job(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c, input logic [15:0] nb);
    key = k; nonce = n; counter_init = c; num_blocks = nb; start = 1'b1;
    tick();
    start = 1'b0;
    key = ~k; nonce = ~n; counter_init = ~c; num_blocks = 16'h5a5a;
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!ks_bus.ks_valid && cycles < 300) begin
      tick();
      cycles++;
    end
    check({tag, "_valid_seen"}, ks_bus.ks_valid, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_set_state"}, enc_set_state, 1'b0);
    check({tag, "_round_input"}, enc_round_input, '0);
    check({tag, "_ks_valid"}, ks_bus.ks_valid, 1'b0);
    check({tag, "_ks_data"}, ks_bus.ks_data, '0);
    check({tag, "_ks_last"}, ks_bus.ks_last, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ovf"}, ctr_overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int snap_ss, snap_done, snap_rises;
    logic [255:0] k2;
    logic [95:0]  n2;
    logic [511:0] held;

    clear = 1'b1; start = 1'b0; key = '0; nonce = '0; counter_init = '0; num_blocks = '0;
    ks_bus.ks_ready = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    clear = 1'b0;
    tick();

    // RFC 8439 vector, single block.
    ks_bus.ks_ready = 1'b1;
    start_job(RFC_KEY, RFC_NONCE, 32'd1, 16'd1);
    check("rfc_load_set_state", enc_set_state, 1'b1);
    check("rfc_load_state", enc_round_input, tb_state(RFC_KEY, RFC_NONCE, 32'd1));
    wait_valid("rfc", cyc);
    check("rfc_latency", 32'(cyc), 32'(LAT + 1));
    check("rfc_word0", ks_bus.ks_data[31:0], 32'he4e7f110);
    check("rfc_block", ks_bus.ks_data, RFC_KS);
    check("rfc_last", ks_bus.ks_last, 1'b1);
    tick();
    check("rfc_done", done, 1'b1);
    check("rfc_valid_fall", ks_bus.ks_valid, 1'b0);
    tick();
    check("rfc_done_pulse", done, 1'b0);
    check("rfc_idle", busy, 1'b0);

    // Three blocks back to back.
    k2 = {8{32'h13579bdf}} ^ {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    n2 = {32'hcafef00d, 32'h00c0ffee, 32'h8badf00d};
    ss_words.delete();
    start_job(k2, n2, 32'h1000_0005, 16'd3);
    for (int b = 0; b < 3; b++) begin
      wait_valid("multi", cyc);
      check("multi_period", 32'(cyc), 32'(LAT + 1));
      check("multi_data", ks_bus.ks_data, exp_block(k2, n2, 32'h1000_0005 + 32'(b)));
      check("multi_last", ks_bus.ks_last, (b == 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("multi_done", done, 1'b1);
    check("multi_set_count", 32'(ss_words.size()), 32'd3);
    if (ss_words.size() == 3) begin
      check("multi_ctr0", ss_words[0], 32'h1000_0005);
      check("multi_ctr1", ss_words[1], 32'h1000_0006);
      check("multi_ctr2", ss_words[2], 32'h1000_0007);
    end
    tick();

    // Backpressure for 10 cycles on the first of two blocks.
    ks_bus.ks_ready = 1'b0;
    start_job(k2, n2, 32'h0000_0100, 16'd2);
    wait_valid("bp", cyc);
    held = ks_bus.ks_data;
    check("bp_data", held, exp_block(k2, n2, 32'h0000_0100));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", ks_bus.ks_valid, 1'b1);
      check("bp_data_hold", ks_bus.ks_data, held);
      check("bp_no_set_state", enc_set_state, 1'b0);
    end
    ks_bus.ks_ready = 1'b1;
    tick();
    check("bp_reload", enc_set_state, 1'b1);
    check("bp_valid_fall", ks_bus.ks_valid, 1'b0);
    check("bp_reload_ctr", enc_round_input[415:384], 32'h0000_0101);
    wait_valid("bp2", cyc);
    check("bp2_data", ks_bus.ks_data, exp_block(k2, n2, 32'h0000_0101));
    check("bp2_last", ks_bus.ks_last, 1'b1);
    tick();
    check("bp_done", done, 1'b1);
    tick();

    // Zero blocks.
    snap_ss = ss_words.size();
    snap_rises = valid_rises;
    start_job(k2, n2, 32'h0, 16'd0);
    check("zero_done", done, 1'b1);
    check("zero_no_set_state", enc_set_state, 1'b0);
    check("zero_no_valid", ks_bus.ks_valid, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_idle", busy, 1'b0);
    check("zero_set_count", 32'(ss_words.size()), 32'(snap_ss));
    check("zero_valid_rises", 32'(valid_rises), 32'(snap_rises));

    // Clear mid-RUN on block 2, then a fresh job.
    start_job(k2, n2, 32'h0000_0200, 16'd3);
    wait_valid("clr", cyc);
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("clr_in_run", busy, 1'b1);
    snap_done = done_cnt;
    snap_rises = valid_rises;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_outputs("clr");
    for (int i = 0; i < LAT + 5; i++) tick();
    check("clr_no_done", 32'(done_cnt), 32'(snap_done));
    check("clr_no_valid", 32'(valid_rises), 32'(snap_rises));
    start_job(RFC_KEY, RFC_NONCE, 32'd1, 16'd1);
    wait_valid("clr_restart", cyc);
    check("clr_restart_latency", 32'(cyc), 32'(LAT + 1));
    check("clr_restart_block", ks_bus.ks_data, RFC_KS);
    tick();
    check("clr_restart_done", done, 1'b1);
    tick();

    // Counter at 0xFFFFFFFF with two blocks requested.
    start_job(k2, n2, 32'hffff_ffff, 16'd2);
    wait_valid("wrap", cyc);
    check("wrap_data0", ks_bus.ks_data, exp_block(k2, n2, 32'hffff_ffff));
    check("wrap_last0", ks_bus.ks_last, 1'b0);
    tick();
`ifdef CHACHA20_CTR_OVERFLOW_EN
    check("ovf_done", done, 1'b1);
    check("ovf_flag", ctr_overflow, 1'b1);
    check("ovf_no_load", enc_set_state, 1'b0);
    tick();
    check("ovf_sticky", ctr_overflow, 1'b1);
    check("ovf_idle", busy, 1'b0);
    start_job(k2, n2, 32'h0, 16'd0);
    check("ovf_cleared_by_start", ctr_overflow, 1'b0);
    tick();
`else
    check("wrap_load", enc_set_state, 1'b1);
    check("wrap_ctr0", enc_round_input[415:384], 32'h0000_0000);
    wait_valid("wrap2", cyc);
    check("wrap_data1", ks_bus.ks_data, exp_block(k2, n2, 32'h0000_0000));
    check("wrap_last1", ks_bus.ks_last, 1'b1);
    tick();
    check("wrap_done", done, 1'b1);
    tick();
`endif
    check("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
